// File: rtl/mon_pkg.sv
// Shared types and constants for the simulation mailbox monitor.
// The optional stall detector is enabled with MON_STALL_DETECT_EN.
package mon_pkg;

   typedef enum logic [0:0] {
      MON_RUN  = 1'b0,
      MON_DONE = 1'b1
   } mon_state_e;

   localparam logic [7:0] PASS_CODE    = 8'h01;
   localparam logic [7:0] FAIL_CODE    = 8'hFF;
   localparam logic [7:0] TIMEOUT_CODE = 8'h00;
   localparam logic [7:0] STALL_CODE   = 8'hFE;

   localparam int CH_STATUS  = 0;
   localparam int CH_CONSOLE = 1;
   localparam int CH_USER0   = 2;

   function automatic logic is_term_code(input logic [7:0] code);
      return (code == PASS_CODE) || (code == FAIL_CODE);
   endfunction

endpackage

// File: rtl/mon_fifo.sv
// First-word fall-through FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module mon_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             full_s;
   logic             empty_s;
   logic             do_push_s;
   logic             do_pop_s;

   // Occupancy flags and the qualified push/pop (a full FIFO may accept a push when it also pops)
   always_comb begin
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      do_pop_s  = pop && !empty_s;
      do_push_s = push && (!full_s || do_pop_s);
   end

   // Storage and pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
            wr_ptr_r                <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   assign rdata = mem_r[rd_ptr_r[AW-1:0]];
   assign full  = full_s;
   assign empty = empty_s;

endmodule

// File: rtl/sim_mailbox_monitor.sv
// Test-harness bus monitor: status/exit, console FIFO and user mailbox channels.
// Define MON_STALL_DETECT_EN to add instruction-fetch stall detection.
module sim_mailbox_monitor
   import mon_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_CH     = 4,
   parameter int CON_DEPTH  = 16,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 100000
`ifdef MON_STALL_DETECT_EN
   , parameter int STALL_CYCLES = 1024
`endif
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          bus_write_i,
   input  logic [ADDR_W-1:0]             bus_addr_i,
   input  logic [DATA_W-1:0]             bus_wdata_i,
   input  logic [ADDR_W-1:0]             mailbox_base_i,
   output logic                          done_o,
   output logic                          pass_o,
   output logic                          fail_o,
   output logic                          timeout_o,
   output logic [7:0]                    exit_code_o,
   output logic [CNT_W-1:0]              cycle_cnt_o,
   output logic                          con_valid_o,
   output logic [7:0]                    con_data_o,
   input  logic                          con_ready_i,
   output logic                          con_overflow_o,
   output logic [(NUM_CH-2)*DATA_W-1:0]  user_o
`ifdef MON_STALL_DETECT_EN
   , input  logic                        inst_read_i
   , output logic                        stall_o
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ALL_ONES = {CNT_W{1'b1}};

   mon_state_e                  state_r;
   mon_state_e                  next_state_s;
   logic                        done_r, pass_r, fail_r, timeout_r;
   logic                        next_done_s, next_pass_s, next_fail_s, next_timeout_s;
   logic [7:0]                  exit_code_r;
   logic [7:0]                  next_exit_code_s;
   logic [CNT_W-1:0]            cycle_cnt_r;
   logic [NUM_CH-1:0]           hit_s;
   logic                        status_term_s;
   logic                        timeout_hit_s;
   logic                        con_push_s;
   logic                        con_pop_s;
   logic                        con_full_s;
   logic                        con_empty_s;
   logic [7:0]                  con_rdata_s;
   logic                        con_overflow_r;
   logic [(NUM_CH-2)*DATA_W-1:0] user_r;

`ifdef MON_STALL_DETECT_EN
   logic [31:0]                 stall_cnt_r;
   logic                        stall_hit_s;
   logic                        stall_r;
   logic                        next_stall_s;
`endif

   // Channel decode: exact word address only, full-width compare
   always_comb begin
      hit_s = {NUM_CH{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         hit_s[k] = bus_write_i && (bus_addr_i == (mailbox_base_i + ADDR_W'(4 * k)));
      end
   end

   // Terminating-event detection
   always_comb begin
      status_term_s = hit_s[CH_STATUS] && is_term_code(bus_wdata_i[7:0]);
      if (MAX_CYCLES != 0) begin
         timeout_hit_s = (cycle_cnt_r == CNT_W'(MAX_CYCLES - 1));
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

`ifdef MON_STALL_DETECT_EN
   assign stall_hit_s = !inst_read_i && (stall_cnt_r == 32'(STALL_CYCLES - 1));

   // Cycles since the last instruction fetch
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_r <= 32'd0;
      end else if (inst_read_i) begin
         stall_cnt_r <= 32'd0;
      end else if (stall_cnt_r != 32'hFFFF_FFFF) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end
`endif

   // Next state and next flag values; a status write beats every other terminator
   always_comb begin
      next_state_s     = state_r;
      next_done_s      = done_r;
      next_pass_s      = pass_r;
      next_fail_s      = fail_r;
      next_timeout_s   = timeout_r;
      next_exit_code_s = exit_code_r;
`ifdef MON_STALL_DETECT_EN
      next_stall_s     = stall_r;
`endif
      case (state_r)
         MON_RUN: begin
            if (status_term_s) begin
               next_state_s     = MON_DONE;
               next_done_s      = 1'b1;
               next_pass_s      = (bus_wdata_i[7:0] == PASS_CODE);
               next_fail_s      = (bus_wdata_i[7:0] == FAIL_CODE);
               next_exit_code_s = bus_wdata_i[7:0];
            end
`ifdef MON_STALL_DETECT_EN
            else if (stall_hit_s) begin
               next_state_s     = MON_DONE;
               next_done_s      = 1'b1;
               next_stall_s     = 1'b1;
               next_exit_code_s = STALL_CODE;
            end
`endif
            else if (timeout_hit_s) begin
               next_state_s     = MON_DONE;
               next_done_s      = 1'b1;
               next_timeout_s   = 1'b1;
               next_exit_code_s = TIMEOUT_CODE;
            end else begin
               next_state_s     = MON_RUN;
            end
         end
         MON_DONE: begin
            next_state_s = MON_DONE;
         end
         default: begin
            next_state_s = MON_RUN;
         end
      endcase
   end

   // State and result flag registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= MON_RUN;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         timeout_r   <= 1'b0;
         exit_code_r <= 8'h00;
      end else begin
         state_r     <= next_state_s;
         done_r      <= next_done_s;
         pass_r      <= next_pass_s;
         fail_r      <= next_fail_s;
         timeout_r   <= next_timeout_s;
         exit_code_r <= next_exit_code_s;
      end
   end

`ifdef MON_STALL_DETECT_EN
   // Stall result flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_r <= 1'b0;
      end else begin
         stall_r <= next_stall_s;
      end
   end

   assign stall_o = stall_r;
`endif

   // Cycle counter: counts in RUN including the terminating edge, saturates
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == MON_RUN) && (cycle_cnt_r != CNT_ALL_ONES)) begin
         cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
         cycle_cnt_r <= cycle_cnt_r;
      end
   end

   assign con_push_s = hit_s[CH_CONSOLE];
   assign con_pop_s  = !con_empty_s && con_ready_i;

   mon_fifo #(
      .DEPTH (CON_DEPTH),
      .WIDTH (8)
   ) u_con_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .push  (con_push_s),
      .wdata (bus_wdata_i[7:0]),
      .pop   (con_pop_s),
      .rdata (con_rdata_s),
      .full  (con_full_s),
      .empty (con_empty_s)
   );

   // Sticky overflow: a byte is lost only when full and nothing drains that cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         con_overflow_r <= 1'b0;
      end else if (con_push_s && con_full_s && !con_pop_s) begin
         con_overflow_r <= 1'b1;
      end else begin
         con_overflow_r <= con_overflow_r;
      end
   end

   // User scratch channels, channel CH_USER0 in the least significant slot
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         user_r <= {((NUM_CH-2)*DATA_W){1'b0}};
      end else begin
         for (int k = CH_USER0; k < NUM_CH; k++) begin
            if (hit_s[k]) begin
               user_r[(k-CH_USER0)*DATA_W +: DATA_W] <= bus_wdata_i;
            end
         end
      end
   end

   assign done_o         = done_r;
   assign pass_o         = pass_r;
   assign fail_o         = fail_r;
   assign timeout_o      = timeout_r;
   assign exit_code_o    = exit_code_r;
   assign cycle_cnt_o    = cycle_cnt_r;
   assign con_valid_o    = !con_empty_s;
   assign con_data_o     = con_rdata_s;
   assign con_overflow_o = con_overflow_r;
   assign user_o         = user_r;

endmodule

// File: doc/sim_mailbox_monitor.md
Name: sim_mailbox_monitor

Overview:
- Synthesizable, parametrised test-harness monitor that sits on the core's data bus, beside the SRAM, in simulation and FPGA test tops.
- Decodes a bank of NUM_CH word-spaced mailbox channels: status/exit, console byte stream, and user scratch registers.
- Tracks cycles with an optional timeout and reports pass/fail/timeout as registered flags, so the bench only polls outputs.
- Console bytes are buffered in a FIFO with a valid/ready drain port.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus write-data width (>= 8)
NUM_CH, 4, mailbox channel count (>= 2); channel k at mailbox_base_i + 4*k
CON_DEPTH, 16, console FIFO depth (power of 2, >= 2)
CNT_W, 32, cycle counter width
MAX_CYCLES, 100000, timeout threshold; 0 disables timeout

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous, active-low reset
bus_write_i  in  1  data-bus write strobe, one cycle per write
bus_addr_i  in  ADDR_W  data-bus byte address
bus_wdata_i  in  DATA_W  data-bus write data
mailbox_base_i  in  ADDR_W  channel 0 address, word aligned, static after reset
done_o  out  1  run ended (pass, fail or timeout)
pass_o  out  1  ended by pass code
fail_o  out  1  ended by fail code
timeout_o  out  1  ended by cycle limit
exit_code_o  out  8  status byte that ended the run
cycle_cnt_o  out  CNT_W  cycles spent in RUN
con_valid_o  out  1  console FIFO non-empty
con_data_o  out  8  console FIFO head byte
con_ready_i  in  1  console consumer pop
con_overflow_o  out  1  sticky: a console byte was dropped
user_o  out  (NUM_CH-2)*DATA_W  last value written to channels 2..NUM_CH-1, channel 2 in LSBs

Behaviour:
Reset values:
- All outputs 0; FSM in RUN; FIFO empty; user registers 0.
- Reset is asynchronous, so asserting rst_ni low mid-run clears everything immediately, including FIFO contents and the overflow flag.

Decode:
- Channel k is hit when bus_write_i=1 and bus_addr_i == mailbox_base_i + 4*k (full-width compare).
- Only the exact word address matches; no byte-lane aliasing.

FSM states and transitions:
- RUN -> DONE on a status write (channel 0) whose wdata[7:0] is PASS_CODE 8'h01 or FAIL_CODE 8'hFF.
- Other status bytes are ignored: no state change, exit_code_o not updated.
- RUN -> DONE on timeout, when MAX_CYCLES != 0 and cycle_cnt == MAX_CYCLES-1 at the clock edge.
- DONE is terminal until reset.

Flags and latency:
- done_o, pass_o/fail_o/timeout_o and exit_code_o update on the edge that samples the terminating event, so they are visible one cycle after the write.
- Exactly one of pass_o/fail_o/timeout_o is set in DONE.
- Timeout gives exit_code_o = 8'h00.
- If a terminating status write and the timeout condition coincide, the status write wins and timeout_o stays 0.

Cycle counter:
- Increments every cycle in RUN and freezes in DONE.
- Saturates at all-ones and does not wrap.

Console FIFO (channel 1):
- A push writes wdata[7:0], accepted in both RUN and DONE.
- Pop occurs when con_valid_o && con_ready_i.
- con_data_o is the head entry, first-word fall-through, so a byte pushed at edge N is valid after edge N.
- Full with push and no pop: the byte is dropped and con_overflow_o is set (sticky).
- Full with push and pop in the same cycle: both happen and no overflow.
- Empty with push and con_ready_i high: push only.
- Read and write pointers carry an extra wrap bit.

User channels:
- A write to channel k >= 2 loads the full DATA_W word into its slot.
- Writes are accepted in any state.

Optional Feature:
Macro MON_STALL_DETECT_EN.
- When defined: adds parameter STALL_CYCLES (default 1024), input inst_read_i and output stall_o.
- A counter resets on every inst_read_i pulse.
- When the counter reaches STALL_CYCLES in RUN: go to DONE with stall_o=1, timeout_o=0 and exit_code_o=8'hFE.
- A terminating status write on the same edge wins.
- When undefined: no port, no counter, behaviour as above.

Decomposition:
- Package mon_pkg holds:
  - state enum {MON_RUN, MON_DONE};
  - PASS_CODE, FAIL_CODE, TIMEOUT_CODE 8'h00, STALL_CODE 8'hFE;
  - channel index constants CH_STATUS=0, CH_CONSOLE=1, CH_USER0=2.
- One sub-module, mon_fifo: a parametrised DEPTH x WIDTH FWFT FIFO with push/pop/full/empty, used for the console.

Test Plan:
- Base 0x1000; write 0x1000 <- 0x00000001 at cycle 50 -> at cycle 51 done_o=1, pass_o=1, exit_code_o=0x01, cycle_cnt_o=51, frozen thereafter.
- Write 0x1000 <- 0x42, then 0x1000 <- 0xFF -> 0x42 ignored; after the second write fail_o=1, exit_code_o=0xFF.
- MAX_CYCLES=20, no writes -> done_o and timeout_o rise after edge 20, cycle_cnt_o=20, exit_code_o=0x00.
- MAX_CYCLES=20, pass write sampled on edge 20 -> pass_o=1, timeout_o=0.
- con_ready_i=0; push 17 bytes 0x41.. to 0x1004 with CON_DEPTH=16 -> con_overflow_o=1 after the 17th. Then drain -> 16 bytes 0x41..0x50 in order; con_valid_o drops after the last.
- Write 0x1008 <- 0xDEADBEEF and 0x100C <- 0x12345678, pulse rst_ni low mid-run -> user_o holds both words before reset; after reset all outputs 0 and FIFO empty.
